// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It bypasses write-back into the incoming and held operands,
// inserts one bubble on a load-use hazard, and supports a synchronous flush.
module id_ex_stage #(
  parameter int BITS     = 64,
  parameter int DEPTH    = 32,
  parameter int CTRLW    = 16,
  parameter int LOAD_BIT = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic             in_uses_rs1,
  input  logic             in_uses_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_rd_we,
  input  logic [CTRLW-1:0] in_ctrl,
  input  logic [BITS-1:0]  in_imm,
  input  logic [BITS-1:0]  rf_read1,
  input  logic [BITS-1:0]  rf_read2,
  input  logic [AW-1:0]    wb_addr,
  input  logic [BITS-1:0]  wb_data,
  input  logic             wb_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_rs1_val,
  output logic [BITS-1:0]  out_rs2_val,
  output logic [AW-1:0]    out_rs1,
  output logic [AW-1:0]    out_rs2,
  output logic [AW-1:0]    out_rd,
  output logic             out_rd_we,
  output logic [CTRLW-1:0] out_ctrl,
  output logic [BITS-1:0]  out_imm,
  output logic             hazard
);

  logic [BITS-1:0] op1, op2;
  logic            wb_live;
  logic            dep_rs1, dep_rs2;
  logic            held_load;
  logic            accept;

  // x0 is never forwarded; the register file supplies its value.
  assign wb_live = wb_en && (wb_addr != '0);
  assign op1     = (wb_live && wb_addr == in_rs1) ? wb_data : rf_read1;
  assign op2     = (wb_live && wb_addr == in_rs2) ? wb_data : rf_read2;

  assign held_load = out_valid && out_ctrl[LOAD_BIT] && out_rd_we && (out_rd != '0);
  assign dep_rs1   = in_uses_rs1 && (in_rs1 == out_rd);
  assign dep_rs2   = in_uses_rs2 && (in_rs2 == out_rd);
  assign hazard    = in_valid && held_load && (dep_rs1 || dep_rs2);

  assign in_ready = flush || ((!out_valid || out_ready) && !hazard);
  assign accept   = in_valid && in_ready;

  // NOTE: all pipeline state uses non-blocking assignments so every field samples
  // the pre-edge values; the payload is a flop bank rather than a memory, so it resets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_ctrl    <= '0;
      out_imm     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_rs1_val <= op1;
      out_rs2_val <= op2;
      out_rs1     <= in_rs1;
      out_rs2     <= in_rs2;
      out_rd      <= in_rd;
      out_rd_we   <= in_rd_we;
      out_ctrl    <= in_ctrl;
      out_imm     <= in_imm;
    end else if (out_valid && out_ready) begin
      // This branch covers both the load-use bubble and a normal drain.
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // A stalled instruction must still see results that retire while it waits.
      if (wb_live && wb_addr == out_rs1) out_rs1_val <= wb_data;
      if (wb_live && wb_addr == out_rs2) out_rs2_val <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. It covers reset, bypass, load-use,
// backpressure, flush, throughput and asynchronous reset.
module tb_id_ex_stage;

  localparam int BITS = 64, AW = 5, CTRLW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [AW-1:0]    in_rs1, in_rs2, in_rd;
  logic             in_uses_rs1, in_uses_rs2, in_rd_we;
  logic [CTRLW-1:0] in_ctrl;
  logic [BITS-1:0]  in_imm, rf_read1, rf_read2, wb_data;
  logic [AW-1:0]    wb_addr;
  logic             wb_en, flush;
  logic             out_valid, out_ready;
  logic [BITS-1:0]  out_rs1_val, out_rs2_val, out_imm;
  logic [AW-1:0]    out_rs1, out_rs2, out_rd;
  logic             out_rd_we;
  logic [CTRLW-1:0] out_ctrl;
  logic             hazard;

  int total = 0;
  int bad   = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_ctrl(in_ctrl), .in_imm(in_imm),
    .rf_read1(rf_read1), .rf_read2(rf_read2), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_en(wb_en), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_ctrl(out_ctrl),
    .out_imm(out_imm), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic u1, input logic u2, input logic [AW-1:0] rd,
                       input logic [CTRLW-1:0] ctrl, input logic [BITS-1:0] imm);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_uses_rs1 = u1; in_uses_rs2 = u2;
    in_rd = rd; in_rd_we = 1'b1; in_ctrl = ctrl; in_imm = imm;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rf_read1 = 64'h5; rf_read2 = 64'h6;
    instr(5'd3, 5'd4, 1'b1, 1'b1, 5'd10, 16'h0, 64'h123);

    // Reset held with a valid instruction offered
    cycle(); cycle();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_rs1_val", out_rs1_val, 64'd0);
    check("rst_imm", out_imm, 64'd0);
    check("rst_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);

    // Release reset, then test write-back bypass on rs1=3
    rst_n = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'hAA;
    check("acc_ready", 64'(in_ready), 64'd1);
    cycle();
    check("lat_valid", 64'(out_valid), 64'd1);
    check("byp_rs1_val", out_rs1_val, 64'hAA);
    check("byp_rs2_val", out_rs2_val, 64'h6);
    check("lat_rd", 64'(out_rd), 64'd10);
    check("lat_imm", out_imm, 64'h123);

    // A write-back to x0 must not bypass
    instr(5'd0, 5'd4, 1'b1, 1'b1, 5'd11, 16'h0, 64'h124);
    wb_addr = 5'd0; wb_data = 64'hBB;
    cycle();
    check("x0_rs1_val", out_rs1_val, 64'h5);
    wb_en = 1'b0;

    // Load-use stall on rs2
    instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 16'h1, 64'h200);
    cycle();
    check("ld_ctrl", 64'(out_ctrl), 64'd1);
    instr(5'd1, 5'd7, 1'b1, 1'b1, 5'd8, 16'h0, 64'h77);
    #1;
    check("lu_hazard", 64'(hazard), 64'd1);
    check("lu_ready", 64'(in_ready), 64'd0);
    cycle();
    check("lu_bubble", 64'(out_valid), 64'd0);
    check("lu_hazard_clr", 64'(hazard), 64'd0);
    check("lu_ready_back", 64'(in_ready), 64'd1);
    cycle();
    check("lu_dep_valid", 64'(out_valid), 64'd1);
    check("lu_dep_imm", out_imm, 64'h77);

    // Same dependence but rs2 is not used: no stall
    instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 16'h1, 64'h201);
    cycle();
    instr(5'd1, 5'd7, 1'b1, 1'b0, 5'd8, 16'h0, 64'h78);
    #1;
    check("nolu_hazard", 64'(hazard), 64'd0);
    check("nolu_ready", 64'(in_ready), 64'd1);
    cycle();
    check("nolu_valid", 64'(out_valid), 64'd1);
    check("nolu_imm", out_imm, 64'h78);

    // Backpressure with a write-back to the held rs2=9
    rf_read1 = 64'h11; rf_read2 = 64'h22;
    instr(5'd5, 5'd9, 1'b1, 1'b1, 5'd12, 16'h0, 64'h99);
    cycle();
    out_ready = 1'b0;
    instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 16'h0, 64'hCC);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h55;
    #1;
    check("bp_ready", 64'(in_ready), 64'd0);
    cycle();
    wb_en = 1'b0;
    cycle(); cycle();
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_imm", out_imm, 64'h99);
    check("bp_rs1_val", out_rs1_val, 64'h11);
    check("bp_rs2_val", out_rs2_val, 64'h55);
    check("bp_ready_hold", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    cycle();
    check("bp_next_imm", out_imm, 64'hCC);

    // Flush while holding a valid instruction with another incoming
    out_ready = 1'b0;
    instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd14, 16'h0, 64'hDD);
    flush = 1'b1;
    #1;
    check("fl_ready", 64'(in_ready), 64'd1);
    cycle();
    check("fl_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("fl_gone", 64'(out_valid), 64'd0);

    // Flush together with a load-use hazard: flush wins
    instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 16'h1, 64'h300);
    cycle();
    instr(5'd7, 5'd2, 1'b1, 1'b1, 5'd15, 16'h0, 64'h301);
    flush = 1'b1;
    #1;
    check("flhz_hazard", 64'(hazard), 64'd1);
    check("flhz_ready", 64'(in_ready), 64'd1);
    cycle();
    check("flhz_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;

    // Ten independent back-to-back instructions
    for (int i = 0; i < 10; i++) begin
      instr(5'd0, 5'd0, 1'b0, 1'b0, 5'(i + 1), 16'h0, 64'h100 + 64'(i));
      cycle();
      check("tp_valid", 64'(out_valid), 64'd1);
      check("tp_imm", out_imm, 64'h100 + 64'(i));
    end
    in_valid = 1'b0;
    cycle();
    check("tp_drain", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-operation
    instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd20, 16'h0, 64'h400);
    cycle();
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_imm", out_imm, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
